// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: receiver FSM encoding, line levels, width helper.
package rs232_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // Team line polarity: idle low, start high, stop low.
   localparam logic LINE_IDLE  = 1'b0;
   localparam logic LINE_START = 1'b1;
   localparam logic LINE_STOP  = 1'b0;

   // Number of bits needed to hold the value itself (minimum 1).
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned w;
      v = value;
      w = 0;
      while (v > 0) begin
         w = w + 1;
         v = v >> 1;
      end
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for a single asynchronous line; resets to the idle level.
module rs232_sync
   import rs232_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= LINE_IDLE;
         q    <= LINE_IDLE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rs232_des.sv
// RS-232 byte deserializer with req/ack handoff, framing and overrun pulses.
// Define RS232_DES_MAJORITY_EN for a 2-of-3 vote around every sample point.
module rs232_des
   import rs232_pkg::*;
#(
   parameter int unsigned P_CLK_FREQ_HZ = 100000000,
   parameter int unsigned P_BAUD_RATE   = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_req,
   input  logic       rx_ack,
   output logic       frm_err,
   output logic       ovr_err
);

   localparam int unsigned BIT_CNT  = P_CLK_FREQ_HZ / P_BAUD_RATE;
   localparam int unsigned HALF_CNT = BIT_CNT / 2;
   localparam int unsigned CNT_W    = clogb2(BIT_CNT);
`ifdef RS232_DES_MAJORITY_EN
   localparam int unsigned SMP_LAG  = 1;
`else
   localparam int unsigned SMP_LAG  = 0;
`endif
   // cnt counts from 0, so the k-th cycle of a bit is cnt == k-1.
   localparam logic [CNT_W-1:0] START_TGT  = CNT_W'(HALF_CNT - 1);
   localparam logic [CNT_W-1:0] BIT_TGT    = CNT_W'(BIT_CNT - 1);
   // Decision lands SMP_LAG cycles late; reload keeps the bit period exact.
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SMP_LAG);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       shreg, shreg_next;
   logic [7:0]       rx_data_next;
   logic             rx_req_next;
   logic             frm_err_next;
   logic             ovr_err_next;
   logic             rx_s;
   logic [CNT_W-1:0] target;
   logic             smp_point;
   logic             smp_val;
   logic             stop_done;
   logic             stop_bit;
   logic             frame_ok;

   rs232_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   assign target = (state == S_START) ? START_TGT : BIT_TGT;

`ifdef RS232_DES_MAJORITY_EN
   logic [1:0] vote, vote_next;

   assign smp_point = (cnt == target + CNT_W'(1));
   assign smp_val   = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);

   // Capture the two samples preceding the decision cycle.
   always_comb begin
      vote_next = vote;
      if (cnt == target - CNT_W'(1)) begin
         vote_next[0] = rx_s;
      end
      if (cnt == target) begin
         vote_next[1] = rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vote <= 2'b00;
      end else begin
         vote <= vote_next;
      end
   end
`else
   assign smp_point = (cnt == target);
   assign smp_val   = rx_s;
`endif

   // Next-state, datapath and handoff decisions.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      shreg_next   = shreg;
      stop_done    = 1'b0;
      stop_bit     = LINE_STOP;
      rx_data_next = rx_data;
      rx_req_next  = rx_req;
      frm_err_next = 1'b0;
      ovr_err_next = 1'b0;
      frame_ok     = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_next     = '0;
            bit_idx_next = 3'd0;
            if (rx_s == LINE_START) begin
               state_next = S_START;
            end
         end
         S_START: begin
            if (smp_point) begin
               if (smp_val == LINE_START) begin
                  cnt_next   = CNT_RELOAD;
                  state_next = S_DATA;
               end else begin
                  cnt_next   = '0;
                  state_next = S_IDLE;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (smp_point) begin
               shreg_next   = {smp_val, shreg[7:1]};
               cnt_next     = CNT_RELOAD;
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_next = S_STOP;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (smp_point) begin
               stop_done  = 1'b1;
               stop_bit   = smp_val;
               cnt_next   = '0;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = S_IDLE;
         end
      endcase

      frame_ok     = stop_done && (stop_bit == LINE_STOP);
      frm_err_next = stop_done && (stop_bit != LINE_STOP);

      // An ack in the completion cycle frees the slot for the new byte.
      if (frame_ok) begin
         if (!rx_req || rx_ack) begin
            rx_data_next = shreg;
            rx_req_next  = 1'b1;
         end else begin
            ovr_err_next = 1'b1;
         end
      end else if (rx_req && rx_ack) begin
         rx_req_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
         rx_data <= 8'h00;
         rx_req  <= 1'b0;
         frm_err <= 1'b0;
         ovr_err <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shreg   <= shreg_next;
         rx_data <= rx_data_next;
         rx_req  <= rx_req_next;
         frm_err <= frm_err_next;
         ovr_err <= ovr_err_next;
      end
   end

endmodule

// File: tb/tb_rs232_des.sv
// Bench for rs232_des at 10 clocks per bit; outcome-level model of the byte handoff.
`timescale 1ns/1ps
module tb_rs232_des;

   localparam int unsigned T    = 10;
   localparam int unsigned HALF = 5;
`ifdef RS232_DES_MAJORITY_EN
   localparam int unsigned LAG  = 1;
`else
   localparam int unsigned LAG  = 0;
`endif
   // Edges from start-bit drive to the cycle in which the stop decision is made.
   localparam int unsigned ACK_EDGES = 2 + HALF + 9 * T + LAG;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_req;
   logic       rx_ack;
   logic       frm_err;
   logic       ovr_err;

   int checks;
   int errors;
   int obs_frm;
   int obs_ovr;
   int exp_frm;
   int exp_ovr;
   bit         m_req;
   logic [7:0] m_data;

   rs232_des #(
      .P_CLK_FREQ_HZ (1000000),
      .P_BAUD_RATE   (100000)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (rx),
      .rx_data (rx_data),
      .rx_req  (rx_req),
      .rx_ack  (rx_ack),
      .frm_err (frm_err),
      .ovr_err (ovr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every cycle a flag is high, so a stretched pulse shows up.
   always @(negedge clk) begin
      if (frm_err === 1'b1) obs_frm++;
      if (ovr_err === 1'b1) obs_ovr++;
   end

   // Reference model: outcome of a completed frame.
   task automatic model_frame(input logic [7:0] b, input bit stop_v, input bit ack_same);
      if (stop_v) exp_frm++;
      else if (!m_req || ack_same) begin
         m_req  = 1'b1;
         m_data = b;
      end else exp_ovr++;
   endtask

   task automatic model_ack();
      m_req = 1'b0;
   endtask

   task automatic line_idle(input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         @(posedge clk);
         #1 rx = 1'b0;
      end
   endtask

   // Drive start, 8 data bits LSB first, stop; optional one-cycle inversion mid-bit.
   task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit glitch);
      logic [9:0] bits;
      bits = {stop_v, b, 1'b1};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 rx = bits[i];
         for (int c = 1; c < int'(T); c++) begin
            @(posedge clk);
            #1 rx = (glitch && c == int'(HALF)) ? ~bits[i] : bits[i];
         end
      end
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      rx_ack = 1'b1;
      @(posedge clk);
      #1 rx_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx    = 1'b0;
      rx_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (rx_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", rx_req); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      checks++; if (frm_err !== 1'b0 || ovr_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got frm=%b ovr=%b expected 0 0", frm_err, ovr_err); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_req = 1'b0; m_data = 8'h00;
   endtask

   task automatic test_basic();
      bit got;
      got = 1'b0;
      fork
         send_frame(8'hA5, 1'b0, 1'b0);
         begin
            for (int i = 0; i < int'(12 * T); i++) begin
               @(negedge clk);
               if (rx_req === 1'b1) begin got = 1'b1; break; end
            end
            checks++; if (!got) begin errors++; $display("FAIL basic_req_rise: got no rx_req expected rx_req within %0d cycles", 12 * T); end
            if (got) begin
               model_frame(8'hA5, 1'b0, 1'b0);
               checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data); end
               for (int k = 0; k < 3; k++) begin
                  @(negedge clk);
                  checks++; if (rx_req !== 1'b1 || rx_data !== 8'hA5) begin errors++; $display("FAIL basic_hold: got req=%b data=%h expected 1 a5", rx_req, rx_data); end
               end
               rx_ack = 1'b1;
               @(posedge clk);
               #1 rx_ack = 1'b0;
               model_ack();
               @(negedge clk);
               checks++; if (rx_req !== 1'b0) begin errors++; $display("FAIL basic_req_fall: got %b expected 0", rx_req); end
            end
         end
      join
      line_idle(3);
      @(negedge clk);
      checks++; if (obs_frm != exp_frm || obs_ovr != exp_ovr) begin errors++; $display("FAIL basic_flags: got frm=%0d ovr=%0d expected %0d %0d", obs_frm, obs_ovr, exp_frm, exp_ovr); end
   endtask

   task automatic test_glitch();
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 rx = 1'b0;
      line_idle(2 * T);
      @(negedge clk);
      checks++; if (rx_req !== m_req) begin errors++; $display("FAIL glitch_req: got %b expected %b", rx_req, m_req); end
      checks++; if (obs_frm != exp_frm) begin errors++; $display("FAIL glitch_frm: got %0d expected %0d", obs_frm, exp_frm); end
      checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL glitch_idle: got state %0d expected 0", dut.state); end
   endtask

   task automatic test_frame_error();
      send_frame(8'h3C, 1'b1, 1'b0);
      line_idle(2 * T);
      model_frame(8'h3C, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (obs_frm != exp_frm) begin errors++; $display("FAIL frm_pulse: got %0d expected %0d", obs_frm, exp_frm); end
      checks++; if (rx_req !== m_req || rx_data !== m_data) begin errors++; $display("FAIL frm_keep: got req=%b data=%h expected %b %h", rx_req, rx_data, m_req, m_data); end
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b0, 1'b0);
      model_frame(8'h11, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0);
      model_frame(8'h22, 1'b0, 1'b0);
      line_idle(3);
      @(negedge clk);
      checks++; if (rx_req !== m_req || rx_data !== m_data) begin errors++; $display("FAIL ovr_keep: got req=%b data=%h expected %b %h", rx_req, rx_data, m_req, m_data); end
      checks++; if (obs_ovr != exp_ovr) begin errors++; $display("FAIL ovr_pulse: got %0d expected %0d", obs_ovr, exp_ovr); end
      pulse_ack();
      model_ack();
      @(negedge clk);
      checks++; if (rx_req !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b expected 0", rx_req); end
   endtask

   task automatic test_coincident();
      send_frame(8'h11, 1'b0, 1'b0);
      model_frame(8'h11, 1'b0, 1'b0);
      fork
         send_frame(8'h22, 1'b0, 1'b0);
         begin
            @(posedge clk);
            repeat (ACK_EDGES) @(posedge clk);
            #1 rx_ack = 1'b1;
            @(posedge clk);
            #1 rx_ack = 1'b0;
         end
      join
      model_frame(8'h22, 1'b0, 1'b1);
      line_idle(3);
      @(negedge clk);
      checks++; if (rx_req !== m_req || rx_data !== m_data) begin errors++; $display("FAIL coin_load: got req=%b data=%h expected %b %h", rx_req, rx_data, m_req, m_data); end
      checks++; if (obs_ovr != exp_ovr) begin errors++; $display("FAIL coin_ovr: got %0d expected %0d", obs_ovr, exp_ovr); end
      pulse_ack();
      model_ack();
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (4 * T) @(posedge clk);
      #1 begin rst_n = 1'b0; rx = 1'b0; end
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_req = 1'b0; m_data = 8'h00;
      @(negedge clk);
      checks++; if (rx_req !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_clear: got req=%b data=%h expected 0 00", rx_req, rx_data); end
      line_idle(2 * T);
      send_frame(8'h5A, 1'b0, 1'b0);
      model_frame(8'h5A, 1'b0, 1'b0);
      line_idle(3);
      @(negedge clk);
      checks++; if (rx_req !== m_req || rx_data !== m_data) begin errors++; $display("FAIL rstmid_frame: got req=%b data=%h expected %b %h", rx_req, rx_data, m_req, m_data); end
      checks++; if (obs_frm != exp_frm || obs_ovr != exp_ovr) begin errors++; $display("FAIL rstmid_flags: got frm=%0d ovr=%0d expected %0d %0d", obs_frm, obs_ovr, exp_frm, exp_ovr); end
      pulse_ack();
      model_ack();
   endtask

`ifdef RS232_DES_MAJORITY_EN
   task automatic test_majority();
      line_idle(2);
      send_frame(8'h5A, 1'b0, 1'b1);
      model_frame(8'h5A, 1'b0, 1'b0);
      line_idle(3);
      @(negedge clk);
      checks++; if (rx_req !== m_req || rx_data !== m_data) begin errors++; $display("FAIL maj_frame: got req=%b data=%h expected %b %h", rx_req, rx_data, m_req, m_data); end
      checks++; if (obs_frm != exp_frm) begin errors++; $display("FAIL maj_frm: got %0d expected %0d", obs_frm, exp_frm); end
      pulse_ack();
      model_ack();
   endtask
`endif

   task automatic test_random();
      logic [7:0] b;
      bit sv;
      for (int n = 0; n < 14; n++) begin
         b  = 8'($urandom);
         sv = ($urandom_range(0, 3) == 0);
         send_frame(b, sv, 1'b0);
         if (sv) line_idle(T + $urandom_range(0, 3));
         else    line_idle($urandom_range(1, 4));
         model_frame(b, sv, 1'b0);
         @(negedge clk);
         checks++; if (rx_req !== m_req || rx_data !== m_data) begin errors++; $display("FAIL rand_out[%0d]: got req=%b data=%h expected %b %h", n, rx_req, rx_data, m_req, m_data); end
         checks++; if (obs_frm != exp_frm || obs_ovr != exp_ovr) begin errors++; $display("FAIL rand_flags[%0d]: got frm=%0d ovr=%0d expected %0d %0d", n, obs_frm, obs_ovr, exp_frm, exp_ovr); end
         if ($urandom_range(0, 1) == 1) begin
            pulse_ack();
            model_ack();
            @(negedge clk);
            checks++; if (rx_req !== m_req) begin errors++; $display("FAIL rand_ack[%0d]: got %b expected %b", n, rx_req, m_req); end
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      obs_frm = 0; obs_ovr = 0; exp_frm = 0; exp_ovr = 0;
      m_req = 1'b0; m_data = 8'h00;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_coincident();
      test_reset_mid();
`ifdef RS232_DES_MAJORITY_EN
      test_majority();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion before 5 ms");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
